enc_input_key: RTL and testbench
================================

Name: enc_input_key

Overview:
- Transmit side of the InputKey/ValidCmd unlock interface. On a single start request it drives the 5-frame key sequence that unlocks the key decoder and selects its Mode.
- Sits between the control/host logic and the decoder's InputKey/ValidCmd inputs; it replaces hand-driven stimulus.
- Handshake toward the host is Start, then Busy, then Done.

Parameters:
- UNLOCK, 4'b0101: unlock pattern carried in InputKey[3:0] of every frame. The decoder requires bit0=1, bit1=0, bit2=1, bit3=0, so only 4'b0101 unlocks it; other values are for negative testing.
- GAP_CYCLES, 0: idle cycles with ValidCmd low between consecutive frames. Legal range 0..255.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- Start  input  1  request to send one sequence. Sampled only in IDLE.
- ModeIn  input  1  mode to deliver. Latched on the cycle Start is accepted.
- Abort  input  1  synchronous cancel of a sequence in progress.
- InputKey  output  5  key frame to the decoder.
- ValidCmd  output  1  frame qualifier; exactly one cycle high per frame.
- Busy  output  1  high while a sequence is in progress.
- Done  output  1  one-cycle pulse when a sequence completes normally.

Behaviour:
- Reset (Reset=0, asynchronous):
  - InputKey=5'b00000, ValidCmd=0, Busy=0, Done=0.
  - State IDLE; frame counter, gap counter and latched mode all cleared.
  - Reset mid-sequence abandons the sequence immediately; no Done is produced.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SEND, GAP.
- IDLE:
  - Start=1 at a rising edge: latch ModeIn, set frame=0, go to SEND, Busy=1.
  - Start=0: stay in IDLE with outputs at their reset values, except Done (see below).
- SEND (lasts one cycle):
  - ValidCmd=1. InputKey={bit4, UNLOCK}, where bit4=0 for frames 0..3 and bit4=latched mode for frame 4.
  - frame<4 and GAP_CYCLES>0: go to GAP with gap counter loaded to GAP_CYCLES.
  - frame<4 and GAP_CYCLES=0: stay in SEND with frame+1, giving back-to-back frames.
  - frame=4: go to IDLE; Busy=0 and Done=1 for exactly one cycle.
- GAP:
  - ValidCmd=0 and InputKey=5'b00000.
  - Counter decrements each cycle. At count 1, go to SEND with frame+1.
- Sequence timing:
  - ValidCmd first rises one cycle after Start is sampled.
  - Busy is high for 5+4*GAP_CYCLES cycles.
  - Done rises in the cycle after frame 4's ValidCmd cycle.
- Start handling:
  - Start is ignored while Busy=1.
  - Start sampled during the Done cycle is accepted, giving back-to-back sequences with no extra idle cycle.
- Abort:
  - Abort=1 at a rising edge while Busy: go to IDLE, ValidCmd=0, InputKey=0, Busy=0, no Done.
  - Abort has priority over frame advance.
  - Abort in IDLE has no effect, and Start in that same cycle is still accepted.
- ModeIn changes after acceptance have no effect on the sequence in progress.
- Counter widths: frame counter 3 bits, never exceeds 4. Gap counter 8 bits; it never wraps.

Test Plan:
- GAP_CYCLES=0, ModeIn=1, pulse Start -> ValidCmd high 5 consecutive cycles with InputKey 00101, 00101, 00101, 00101, 10101; Busy high 5 cycles; Done pulse in the 6th; a connected decoder ends with Active=1, Mode=1.
- GAP_CYCLES=2, ModeIn=0 -> frames 3 cycles apart, InputKey=00000 in the gaps, Busy high 13 cycles, last frame 00101, decoder Mode=0.
- Start pulsed again mid-sequence and ModeIn toggled after acceptance -> no restart, frame order unchanged, last frame bit4 still equals the mode latched at acceptance.
- Abort asserted during frame 2 -> next cycle ValidCmd=0, Busy=0, InputKey=0, no Done; a new Start then yields a full 5-frame sequence.
- Reset driven low during a GAP -> outputs zero immediately, before the next clock edge; after release, IDLE with no spurious ValidCmd.
- Start held high through the Done cycle -> second sequence begins with ValidCmd one cycle after Done; two Done pulses total.

Source files
------------

// File: rtl/enc_input_key.sv
// enc_input_key
// Transmit side of the InputKey/ValidCmd unlock interface. A single accepted
// Start request produces the 5-frame key sequence that unlocks the key decoder
// and selects its Mode. Frames 0..3 carry {0, UNLOCK}; frame 4 carries
// {mode, UNLOCK}, where mode is ModeIn captured when Start was accepted.
// Frames are separated by GAP_CYCLES idle cycles.
//
// Ports:
//   Clk      in   1  system clock, rising edge
//   Reset    in   1  asynchronous reset, active low
//   Start    in   1  request one sequence (only looked at in IDLE)
//   ModeIn   in   1  mode to deliver, captured when Start is accepted
//   Abort    in   1  synchronous cancel of the sequence in progress
//   InputKey out  5  key frame to the decoder
//   ValidCmd out  1  frame qualifier, one cycle high per frame
//   Busy     out  1  high while a sequence is in progress
//   Done     out  1  one-cycle pulse when a sequence completes normally
module enc_input_key #(
  parameter logic [3:0] UNLOCK     = 4'b0101,
  parameter int         GAP_CYCLES = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       ModeIn,
  input  logic       Abort,
  output logic [4:0] InputKey,
  output logic       ValidCmd,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  state_t     state, state_nxt;
  logic [2:0] frame, frame_nxt;
  logic [7:0] gap_cnt, gap_nxt;
  logic       mode, mode_nxt;

  logic [4:0] key_nxt;
  logic       valid_nxt;
  logic       busy_nxt;
  logic       done_nxt;

  logic [2:0] frame_inc;
  logic [4:0] key_inc;

  // Key for the frame after the current one; bit4 carries the latched mode
  // only on the last frame.
  assign frame_inc = frame + 3'd1;
  assign key_inc   = {(frame_inc == 3'd4) ? mode : 1'b0, UNLOCK};

  // Next-state and next-output decode. The outputs are computed for the state
  // being entered and then registered, so no input reaches an output without
  // passing through a flop.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame;
    gap_nxt   = gap_cnt;
    mode_nxt  = mode;
    key_nxt   = 5'b00000;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (Start) begin
          mode_nxt  = ModeIn;
          frame_nxt = 3'd0;
          state_nxt = SEND;
          key_nxt   = {1'b0, UNLOCK};
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      SEND: begin
        if (Abort) begin
          state_nxt = IDLE;
          frame_nxt = 3'd0;
        end else if (frame == 3'd4) begin
          state_nxt = IDLE;
          frame_nxt = 3'd0;
          done_nxt  = 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_nxt = GAP;
          gap_nxt   = GAP_LOAD;
          busy_nxt  = 1'b1;
        end else begin
          frame_nxt = frame_inc;
          key_nxt   = key_inc;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end

      GAP: begin
        if (Abort) begin
          state_nxt = IDLE;
          frame_nxt = 3'd0;
          gap_nxt   = 8'd0;
        end else if (gap_cnt <= 8'd1) begin
          // Leaving at count 1 means the counter never decrements past zero.
          state_nxt = SEND;
          frame_nxt = frame_inc;
          gap_nxt   = 8'd0;
          key_nxt   = key_inc;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          gap_nxt  = gap_cnt - 8'd1;
          busy_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        frame_nxt = 3'd0;
        gap_nxt   = 8'd0;
      end
    endcase
  end

  // State, counters, latched mode and all outputs. The asynchronous reset
  // clears the outputs immediately and abandons any sequence without a Done.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      frame    <= 3'd0;
      gap_cnt  <= 8'd0;
      mode     <= 1'b0;
      InputKey <= 5'b00000;
      ValidCmd <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      frame    <= frame_nxt;
      gap_cnt  <= gap_nxt;
      mode     <= mode_nxt;
      InputKey <= key_nxt;
      ValidCmd <= valid_nxt;
      Busy     <= busy_nxt;
      Done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_enc_input_key.sv
// tb_enc_input_key
// Directed bench for enc_input_key. Instance 0 runs with no gap between
// frames, instance 1 with two idle cycles between frames. Outputs are looked
// at 1 time unit after each rising edge, and inputs are changed there too.
// Every observation is packed as {InputKey, ValidCmd, Busy, Done}.
module tb_enc_input_key;

  logic       Clk;
  logic       Reset;
  logic [1:0] start;
  logic [1:0] mode_in;
  logic [1:0] abort;

  logic [4:0] key0, key1;
  logic       vc0, vc1;
  logic       busy0, busy1;
  logic       done0, done1;

  int testCount;
  int failCount;

  enc_input_key #(.UNLOCK(4'b0101), .GAP_CYCLES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Start(start[0]), .ModeIn(mode_in[0]),
    .Abort(abort[0]), .InputKey(key0), .ValidCmd(vc0), .Busy(busy0),
    .Done(done0)
  );

  enc_input_key #(.UNLOCK(4'b0101), .GAP_CYCLES(2)) dut1 (
    .Clk(Clk), .Reset(Reset), .Start(start[1]), .ModeIn(mode_in[1]),
    .Abort(abort[1]), .InputKey(key1), .ValidCmd(vc1), .Busy(busy1),
    .Done(done1)
  );

  // 10-unit clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [7:0] obs(input int sel);
    if (sel == 0) return {key0, vc0, busy0, done0};
    return {key1, vc1, busy1, done1};
  endfunction

  // Advance to 1 unit past the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got,
                             input logic [7:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got key/vc/busy/done=%b expected %b", tag, got, exp);
    end
  endtask

  // Run one full sequence on instance sel. When disturb is set, Start is
  // pulsed and ModeIn flipped during frame 1; neither may affect the run.
  task automatic applyStimulus(input int sel, input int gap, input logic m,
                               input bit disturb, input string name);
    logic [4:0] k;
    start[sel]   = 1'b1;
    mode_in[sel] = m;
    tick();
    start[sel] = 1'b0;
    for (int f = 0; f < 5; f++) begin
      k = (f == 4) ? {m, 4'b0101} : 5'b00101;
      checkOutput($sformatf("%s frame%0d", name, f), obs(sel), {k, 3'b110});
      if (disturb && f == 1) begin
        start[sel]   = 1'b1;
        mode_in[sel] = ~m;
      end
      tick();
      if (disturb && f == 1) start[sel] = 1'b0;
      if (f < 4) begin
        for (int g = 0; g < gap; g++) begin
          checkOutput($sformatf("%s gap%0d.%0d", name, f, g), obs(sel), 8'b00000_010);
          tick();
        end
      end
    end
    checkOutput($sformatf("%s done", name), obs(sel), 8'b00000_001);
    tick();
    checkOutput($sformatf("%s idle", name), obs(sel), 8'b00000_000);
  endtask

  initial begin
    logic [4:0] k;
    testCount = 0;
    failCount = 0;
    start     = 2'b00;
    mode_in   = 2'b00;
    abort     = 2'b00;
    Reset     = 1'b0;
    #1;
    checkOutput("reset0", obs(0), 8'h00);
    checkOutput("reset1", obs(1), 8'h00);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    checkOutput("idle0", obs(0), 8'h00);

    // Back-to-back frames, mode 1
    applyStimulus(0, 0, 1'b1, 1'b0, "g0m1");
    // Gapped frames, mode 0
    applyStimulus(1, 2, 1'b0, 1'b0, "g2m0");
    // Restart attempt and ModeIn change mid-sequence are ignored
    applyStimulus(1, 2, 1'b1, 1'b1, "g2dist");
    applyStimulus(0, 0, 1'b1, 1'b1, "g0dist");

    // Abort during frame 2: immediate return to IDLE with no Done
    start[0]   = 1'b1;
    mode_in[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    checkOutput("abort frame2", obs(0), 8'b00101_110);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checkOutput("abort idle", obs(0), 8'h00);
    tick();
    checkOutput("abort no done", obs(0), 8'h00);
    applyStimulus(0, 0, 1'b0, 1'b0, "after abort");

    // Abort in IDLE does not block a Start in the same cycle
    start[0] = 1'b1;
    abort[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    checkOutput("idle abort+start", obs(0), 8'b00101_110);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    checkOutput("abort frame0", obs(0), 8'h00);

    // Asynchronous reset during a gap clears outputs before the next edge
    start[1]   = 1'b1;
    mode_in[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    checkOutput("pre-reset frame0", obs(1), 8'b00101_110);
    tick();
    checkOutput("pre-reset gap", obs(1), 8'b00000_010);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("async reset", obs(1), 8'h00);
    tick();
    tick();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("post-reset%0d", i), obs(1), 8'h00);
    end

    // Start held through Done: second sequence starts with no idle cycle
    start[0]   = 1'b1;
    mode_in[0] = 1'b1;
    tick();
    for (int f = 0; f < 5; f++) begin
      k = (f == 4) ? 5'b10101 : 5'b00101;
      checkOutput($sformatf("b2b A frame%0d", f), obs(0), {k, 3'b110});
      tick();
    end
    checkOutput("b2b A done", obs(0), 8'b00000_001);
    mode_in[0] = 1'b0;
    tick();
    start[0] = 1'b0;
    for (int f = 0; f < 5; f++) begin
      checkOutput($sformatf("b2b B frame%0d", f), obs(0), 8'b00101_110);
      tick();
    end
    checkOutput("b2b B done", obs(0), 8'b00000_001);
    tick();
    checkOutput("b2b idle", obs(0), 8'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
